// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target backed by a synchronous word memory.
// Fixed-latency responses, STALL-bounded outstanding requests, ERR on out-of-range addresses.
module wb_tgt_mem #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2,
    parameter int TGD_WIDTH = 1,
    parameter int MEM_AW    = 8,
    parameter int LAT       = 2,
    parameter int MAX_OUT   = 2
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 tgt_cyc_i,
    input  logic                 tgt_stb_i,
    input  logic                 tgt_we_i,
    input  logic                 tgt_lock_i,
    input  logic [SEL_WIDTH-1:0] tgt_sel_i,
    input  logic [ADR_WIDTH-1:0] tgt_adr_i,
    input  logic [DAT_WIDTH-1:0] tgt_dat_i,
    input  logic [TGD_WIDTH-1:0] tgt_tgd_i,
    output logic                 tgt_ack_o,
    output logic                 tgt_err_o,
    output logic                 tgt_rty_o,
    output logic                 tgt_stall_o,
    output logic [DAT_WIDTH-1:0] tgt_dat_o,
    output logic [TGD_WIDTH-1:0] tgt_tgd_o
);

    localparam int LANE_W = DAT_WIDTH / SEL_WIDTH;
    localparam int DEPTH  = 1 << MEM_AW;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);

    logic [DAT_WIDTH-1:0] mem_q [DEPTH];
    logic [TGD_WIDTH-1:0] tag_q [DEPTH];

    logic [LAT-1:0]       vld_q, vld_d;
    logic [LAT-1:0]       err_q, err_d;
    logic [DAT_WIDTH-1:0] rdat_q [LAT];
    logic [DAT_WIDTH-1:0] rdat_d [LAT];
    logic [TGD_WIDTH-1:0] rtgd_q [LAT];
    logic [TGD_WIDTH-1:0] rtgd_d [LAT];
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic              in_range;
    logic              last_vld;
    logic              stall;
    logic              acc;
    logic              wr_en;
    logic              rd_en;
    logic [MEM_AW-1:0] idx;
    logic              unused_lock;

    assign unused_lock = tgt_lock_i;

    generate
        if (MEM_AW < ADR_WIDTH) begin : g_rng
            assign in_range = ~|tgt_adr_i[ADR_WIDTH-1:MEM_AW];
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign idx      = tgt_adr_i[MEM_AW-1:0];
    assign last_vld = vld_q[LAT-1];
    // Stall depends on registers only, so masters never see a cyc/stb -> stall loop.
    assign stall    = (cnt_q == CNT_W'(MAX_OUT)) & ~last_vld;
    assign acc      = tgt_cyc_i & tgt_stb_i & ~stall;
    assign wr_en    = acc & tgt_we_i & in_range;
    assign rd_en    = acc & ~tgt_we_i & in_range;

    always_comb begin
        vld_d = '0;
        err_d = '0;
        for (int k = 0; k < LAT; k++) begin
            rdat_d[k] = '0;
            rtgd_d[k] = '0;
        end
        vld_d[0]  = acc;
        err_d[0]  = acc & ~in_range;
        rdat_d[0] = rd_en ? mem_q[idx] : '0;
        rtgd_d[0] = rd_en ? tag_q[idx] : '0;
        for (int k = 1; k < LAT; k++) begin
            vld_d[k]  = vld_q[k-1];
            err_d[k]  = err_q[k-1];
            rdat_d[k] = rdat_q[k-1];
            rtgd_d[k] = rtgd_q[k-1];
        end
        // Dropping cyc discards every pending response.
        if (!tgt_cyc_i) begin
            vld_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!tgt_cyc_i) begin
            cnt_d = '0;
        end else if (acc && !last_vld) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!acc && last_vld) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload is qualified by vld_q at the output, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LAT; k++) begin
            rdat_q[k] <= rdat_d[k];
            rtgd_q[k] <= rtgd_d[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < SEL_WIDTH; k++) begin
                if (tgt_sel_i[k]) begin
                    mem_q[idx][k*LANE_W +: LANE_W] <= tgt_dat_i[k*LANE_W +: LANE_W];
                end
            end
            if (|tgt_sel_i) begin
                tag_q[idx] <= tgt_tgd_i;
            end
        end
    end

    assign tgt_ack_o   = last_vld & ~err_q[LAT-1];
    assign tgt_err_o   = last_vld & err_q[LAT-1];
    assign tgt_rty_o   = 1'b0;
    assign tgt_stall_o = stall;
    assign tgt_dat_o   = tgt_ack_o ? rdat_q[LAT-1] : '0;
    assign tgt_tgd_o   = tgt_ack_o ? rtgd_q[LAT-1] : '0;

endmodule

// File: tb/tb_wb_tgt_mem.sv
// Directed bench for wb_tgt_mem: three instances (LAT/MAX_OUT = 2/2, 3/1, 3/2)
// share request wires; each has its own cyc line so only one is active at a time.
module tb_wb_tgt_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_a, cyc_b, cyc_c;
    logic        stb, we, lock;
    logic [1:0]  sel;
    logic [15:0] adr, dat;
    logic        tgd;

    logic        ack_a, err_a, rty_a, stall_a, tgdo_a;
    logic        ack_b, err_b, rty_b, stall_b, tgdo_b;
    logic        ack_c, err_c, rty_c, stall_c, tgdo_c;
    logic [15:0] dato_a, dato_b, dato_c;

    int tests = 0;
    int fails = 0;

    logic [10:0] st_exp;
    logic [10:0] ack_exp;

    always #5 clk = ~clk;

    wb_tgt_mem #(.LAT(2), .MAX_OUT(2)) u_a (
        .clk_i(clk), .async_rst_i(rst), .tgt_cyc_i(cyc_a), .tgt_stb_i(stb),
        .tgt_we_i(we), .tgt_lock_i(lock), .tgt_sel_i(sel), .tgt_adr_i(adr),
        .tgt_dat_i(dat), .tgt_tgd_i(tgd), .tgt_ack_o(ack_a), .tgt_err_o(err_a),
        .tgt_rty_o(rty_a), .tgt_stall_o(stall_a), .tgt_dat_o(dato_a), .tgt_tgd_o(tgdo_a)
    );

    wb_tgt_mem #(.LAT(3), .MAX_OUT(1)) u_b (
        .clk_i(clk), .async_rst_i(rst), .tgt_cyc_i(cyc_b), .tgt_stb_i(stb),
        .tgt_we_i(we), .tgt_lock_i(lock), .tgt_sel_i(sel), .tgt_adr_i(adr),
        .tgt_dat_i(dat), .tgt_tgd_i(tgd), .tgt_ack_o(ack_b), .tgt_err_o(err_b),
        .tgt_rty_o(rty_b), .tgt_stall_o(stall_b), .tgt_dat_o(dato_b), .tgt_tgd_o(tgdo_b)
    );

    wb_tgt_mem #(.LAT(3), .MAX_OUT(2)) u_c (
        .clk_i(clk), .async_rst_i(rst), .tgt_cyc_i(cyc_c), .tgt_stb_i(stb),
        .tgt_we_i(we), .tgt_lock_i(lock), .tgt_sel_i(sel), .tgt_adr_i(adr),
        .tgt_dat_i(dat), .tgt_tgd_i(tgd), .tgt_ack_o(ack_c), .tgt_err_o(err_c),
        .tgt_rty_o(rty_c), .tgt_stall_o(stall_c), .tgt_dat_o(dato_c), .tgt_tgd_o(tgdo_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ca, input logic cb, input logic cc, input logic s,
                         input logic w, input logic [1:0] sl, input logic [15:0] a,
                         input logic [15:0] d, input logic t);
        cyc_a = ca; cyc_b = cb; cyc_c = cc;
        stb = s; we = w; sel = sl; adr = a; dat = d; tgd = t;
    endtask

    initial begin
        lock = 1'b0;
        drive(0, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_ack", ack_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_rty", rty_a, 0);
        chk("rst_stall", stall_a, 0);
        chk("rst_dat", dato_a, 0);
        chk("rst_tgd", tgdo_a, 0);
        rst = 1'b0;

        // Write then read the same word
        drive(1, 0, 0, 1, 1, 2'b11, 16'h0005, 16'hBEEF, 1'b1);
        chk("t1_stall", stall_a, 0);
        tick();
        drive(1, 0, 0, 1, 0, 2'b11, 16'h0005, 16'h0000, 1'b0);
        chk("t1_no_early_ack", ack_a, 0);
        tick();
        drive(1, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        chk("t1_wr_ack", ack_a, 1);
        chk("t1_wr_dat", dato_a, 0);
        chk("t1_wr_err", err_a, 0);
        tick();
        chk("t1_rd_ack", ack_a, 1);
        chk("t1_rd_dat", dato_a, 16'hBEEF);
        chk("t1_rd_tgd", tgdo_a, 1);
        tick();
        chk("t1_idle_ack", ack_a, 0);

        // Byte lanes
        drive(1, 0, 0, 1, 1, 2'b11, 16'h0007, 16'h1234, 1'b0);
        tick();
        drive(1, 0, 0, 1, 1, 2'b10, 16'h0007, 16'hAB00, 1'b0);
        tick();
        drive(1, 0, 0, 1, 0, 2'b11, 16'h0007, 16'h0000, 1'b0);
        chk("t2_wr1_ack", ack_a, 1);
        tick();
        drive(1, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        chk("t2_wr2_ack", ack_a, 1);
        tick();
        chk("t2_rd_ack", ack_a, 1);
        chk("t2_rd_dat", dato_a, 16'hAB34);
        tick();

        // Back-to-back reads, never stalled when LAT == MAX_OUT
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 1, 2'b11, 16'(i), 16'(16'h0010 + i), 1'b0);
            chk("t3_pre_stall", stall_a, 0);
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1, 0, 0, 1, 0, 2'b11, 16'(i), 16'h0000, 1'b0);
            else       drive(1, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
            if (i < 4) chk("t3_stall", stall_a, 0);
            if (i >= 2 && i < 6) begin
                chk("t3_ack", ack_a, 1);
                chk("t3_dat", dato_a, 32'(16'h0010 + i - 2));
            end
            if (i == 6) chk("t3_tail_ack", ack_a, 0);
            tick();
        end

        // LAT=3, MAX_OUT=1 throttling
        st_exp  = 11'h1B6;
        ack_exp = 11'h248;
        for (int i = 0; i < 11; i++) begin
            if (i < 7) drive(0, 1, 0, 1, 1, 2'b11, 16'h0020, 16'h4242, 1'b0);
            else       drive(0, 1, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
            chk("t4_stall", stall_b, st_exp[i]);
            chk("t4_ack", ack_b, ack_exp[i]);
            chk("t4_cnt_le1", 32'(u_b.cnt_q <= 1), 1);
            tick();
        end

        // Out-of-range access
        drive(1, 0, 0, 1, 0, 2'b11, 16'h0100, 16'h0000, 1'b0);
        tick();
        drive(1, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        tick();
        drive(1, 0, 0, 1, 1, 2'b11, 16'h0100, 16'hDEAD, 1'b1);
        chk("t5_rd_err", err_a, 1);
        chk("t5_rd_ack", ack_a, 0);
        chk("t5_rd_dat", dato_a, 0);
        tick();
        drive(1, 0, 0, 1, 0, 2'b11, 16'h0000, 16'h0000, 1'b0);
        tick();
        drive(1, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        chk("t5_wr_err", err_a, 1);
        chk("t5_wr_ack", ack_a, 0);
        tick();
        chk("t5_adr0_ack", ack_a, 1);
        chk("t5_adr0_dat", dato_a, 16'h0010);
        tick();

        // Cycle abort discards pending responses
        drive(0, 0, 1, 1, 0, 2'b11, 16'h0000, 16'h0000, 1'b0);
        chk("t6a_stall0", stall_c, 0);
        tick();
        drive(0, 0, 1, 1, 0, 2'b11, 16'h0001, 16'h0000, 1'b0);
        chk("t6a_stall1", stall_c, 0);
        tick();
        drive(0, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        chk("t6a_drop_ack", ack_c, 0);
        tick();
        drive(0, 0, 1, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        chk("t6a_cnt", 32'(u_c.cnt_q), 0);
        for (int i = 0; i < 5; i++) begin
            chk("t6a_ack", ack_c, 0);
            chk("t6a_err", err_c, 0);
            chk("t6a_stall", stall_c, 0);
            tick();
        end

        // Asynchronous reset with requests in flight
        drive(1, 0, 0, 1, 0, 2'b11, 16'h0001, 16'h0000, 1'b0);
        tick();
        drive(1, 0, 0, 1, 0, 2'b11, 16'h0002, 16'h0000, 1'b0);
        tick();
        drive(1, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        chk("t6b_pre_ack", ack_a, 1);
        chk("t6b_pre_dat", dato_a, 16'h0011);
        #3;
        rst = 1'b1;
        #1;
        chk("t6b_rst_ack", ack_a, 0);
        chk("t6b_rst_err", err_a, 0);
        chk("t6b_rst_dat", dato_a, 0);
        chk("t6b_rst_stall", stall_a, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t6b_late_ack", ack_a, 0);
            chk("t6b_late_err", err_a, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
